// File: rtl/md_vel_pkg.sv
// Shared types and constants for the per-cell velocity integrator.
// Component indices select the {vz, vy, vx} slices of a packed word.
package md_vel_pkg;

    localparam int CNT_W  = 8;
    localparam int COMP_X = 0;
    localparam int COMP_Y = 1;
    localparam int COMP_Z = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_RD,
        S_CNT_WAIT,
        S_V_RD,
        S_V_WAIT,
        S_F_WAIT,
        S_WB,
        S_DONE
    } vel_state_e;

    function automatic int comp_lsb(input int comp, input int width);
        return comp * width;
    endfunction

endpackage

// File: rtl/vel_component_add.sv
// One velocity component: v + (f >>> DT_SHIFT).
// VELOCITY_SATURATE_EN clamps on overflow; otherwise the sum wraps.
module vel_component_add #(
    parameter int COMP_WIDTH = 32,
    parameter int DT_SHIFT   = 8
) (
    input  logic [COMP_WIDTH-1:0] v,
    input  logic [COMP_WIDTH-1:0] f,
    output logic [COMP_WIDTH-1:0] sum
);

    logic signed [COMP_WIDTH-1:0] f_sh;
    assign f_sh = $signed(f) >>> DT_SHIFT;

`ifdef VELOCITY_SATURATE_EN
    logic signed [COMP_WIDTH:0] wide;
    assign wide = $signed({v[COMP_WIDTH-1], v}) + $signed({f_sh[COMP_WIDTH-1], f_sh});

    // Top two bits disagree only when the true sum left the COMP_WIDTH range.
    always_comb begin
        sum = wide[COMP_WIDTH-1:0];
        if (wide[COMP_WIDTH] != wide[COMP_WIDTH-1])
            sum = wide[COMP_WIDTH] ? {1'b1, {(COMP_WIDTH-1){1'b0}}}
                                   : {1'b0, {(COMP_WIDTH-1){1'b1}}};
    end
`else
    assign sum = v + f_sh;
`endif

endmodule

// File: rtl/velocity_update_z_y_x.sv
// Per-cell velocity integrator: reads count, then per particle reads v, takes
// one force word, writes v + f*dt back and forwards it. Option: VELOCITY_SATURATE_EN.
module velocity_update_z_y_x
    import md_vel_pkg::*;
#(
    parameter int DATA_WIDTH   = 96,
    parameter int COMP_WIDTH   = 32,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = CNT_W,
    parameter int DT_SHIFT     = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  force_valid,
    output logic                  force_ready,
    input  logic [DATA_WIDTH-1:0] force_data,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_rden,
    output logic                  ram_wren,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr
);

    localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(PARTICLE_NUM - 1);

    vel_state_e            state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx, count, cnt_raw, cnt_clamped;
    logic [DATA_WIDTH-1:0] vel, result, sum;

    assign cnt_raw     = ram_q[ADDR_WIDTH-1:0];
    assign cnt_clamped = (cnt_raw > MAX_IDX) ? MAX_IDX : cnt_raw;

    for (genvar c = COMP_X; c <= COMP_Z; c++) begin : g_comp
        localparam int LSB = comp_lsb(c, COMP_WIDTH);
        vel_component_add #(
            .COMP_WIDTH(COMP_WIDTH),
            .DT_SHIFT  (DT_SHIFT)
        ) u_add (
            .v  (vel[LSB +: COMP_WIDTH]),
            .f  (force_data[LSB +: COMP_WIDTH]),
            .sum(sum[LSB +: COMP_WIDTH])
        );
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_CNT_RD;
            S_CNT_RD:   state_nxt = S_CNT_WAIT;
            S_CNT_WAIT: state_nxt = (cnt_clamped == '0) ? S_DONE : S_V_RD;
            S_V_RD:     state_nxt = S_V_WAIT;
            S_V_WAIT:   state_nxt = S_F_WAIT;
            S_F_WAIT:   if (force_valid) state_nxt = S_WB;
            S_WB:       if (out_ready) state_nxt = (idx == count) ? S_DONE : S_V_RD;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            count  <= '0;
            vel    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_CNT_WAIT: begin
                    count <= cnt_clamped;
                    idx   <= ADDR_WIDTH'(1);
                end
                S_V_WAIT: vel <= ram_q;
                S_F_WAIT: if (force_valid) result <= sum;
                S_WB:     if (out_ready && idx != count) idx <= idx + ADDR_WIDTH'(1);
                default: ;
            endcase
        end
    end

    // Everything is decoded from state so reset zeroes all outputs at once.
    always_comb begin
        busy        = (state != S_IDLE);
        done        = 1'b0;
        force_ready = 1'b0;
        ram_address = '0;
        ram_rden    = 1'b0;
        ram_wren    = 1'b0;
        ram_data    = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_addr    = '0;
        case (state)
            S_CNT_RD: ram_rden = 1'b1;
            S_V_RD: begin
                ram_rden    = 1'b1;
                ram_address = idx;
            end
            S_F_WAIT: force_ready = 1'b1;
            S_WB: begin
                out_valid   = 1'b1;
                out_data    = result;
                out_addr    = idx;
                ram_address = idx;
                ram_data    = result;
                ram_wren    = out_ready;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_velocity_update_z_y_x.sv
// Directed bench for velocity_update_z_y_x with a behavioural cell memory
// and force queue; expected values are hand-computed constants.
module tb_velocity_update_z_y_x;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic        force_valid = 1'b0;
    logic        force_ready;
    logic [95:0] force_data;
    logic [7:0]  ram_address;
    logic        ram_rden, ram_wren;
    logic [95:0] ram_data;
    logic [95:0] ram_q = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [95:0] out_data;
    logic [7:0]  out_addr;

    velocity_update_z_y_x dut (
        .clock(clock), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .force_valid(force_valid), .force_ready(force_ready), .force_data(force_data),
        .ram_address(ram_address), .ram_rden(ram_rden), .ram_wren(ram_wren),
        .ram_data(ram_data), .ram_q(ram_q), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
    );

    always #5 clock = ~clock;

    // cell memory with a loader port for preloading words
    logic [95:0] mem [0:219];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [95:0] ld_data = '0;

    always @(posedge clock) begin
        if (ld_en)         mem[ld_addr] <= ld_data;
        else if (ram_wren) mem[ram_address] <= ram_data;
        if (ram_rden)      ram_q <= mem[ram_address];
    end

    // force queue, consumed one word per handshake
    logic [95:0] fq [0:63];
    int          fidx = 0;
    assign force_data = fq[fidx[5:0]];

    int          n_wren = 0, n_vrd = 0, n_fr = 0, n_bad = 0, n_hs = 0;
    logic [95:0] hs_data [0:63];
    logic [7:0]  hs_addr [0:63];

    always @(posedge clock) begin
        if (force_valid && force_ready) fidx <= fidx + 1;
        if (ram_wren) n_wren <= n_wren + 1;
        if (ram_rden && ram_address != 8'd0) n_vrd <= n_vrd + 1;
        if (force_ready) n_fr <= n_fr + 1;
        if ((ram_rden && ram_wren) || (ram_wren && ram_address == 8'd0)) n_bad <= n_bad + 1;
        if (out_valid && out_ready) begin
            hs_data[n_hs[5:0]] <= out_data;
            hs_addr[n_hs[5:0]] <= out_addr;
            n_hs <= n_hs + 1;
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mem_wr(input logic [7:0] a, input logic [95:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clock); #1;
        ld_en = 1'b0;
    endtask

    task automatic run_pass(output int cyc);
        @(posedge clock); #1;
        start = 1'b1;
        cyc = 0;
        while (cyc < 2000) begin
            @(posedge clock); #1;
            start = 1'b0;
            cyc++;
            if (done) break;
        end
    endtask

    task automatic wait_fready(input string tag);
        int n = 0;
        while (!force_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check(tag, force_ready, 1'b1);
    endtask

    function automatic logic [95:0] v3(input logic [31:0] z, y, x);
        return {z, y, x};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, w0, v0, f0, h0, b0;
        logic [95:0] d, exp2;
        bit stable;

        repeat (3) @(posedge clock);
        #1;
        check("reset_ctrl", {busy, done, force_ready, out_valid, ram_rden, ram_wren}, 6'b0);
        check("reset_bus", {|out_data, |ram_data, |ram_address, |out_addr}, 4'b0);
        rst_n = 1'b1;

        // empty cell
        mem_wr(8'd0, 96'd0);
        w0 = n_wren; v0 = n_vrd; f0 = n_fr;
        run_pass(cyc);
        check("empty_done_cycle", cyc, 3);
        check("empty_writes", n_wren - w0, 0);
        check("empty_vrd", n_vrd - v0, 0);
        check("empty_force_ready", n_fr - f0, 0);

        // basic update, negative force, overflow in both directions
        mem_wr(8'd0, 96'd2);
        mem_wr(8'd1, v3(32'h5, 32'h10, 32'h100));
        mem_wr(8'd2, v3(32'h80000000, 32'h7FFFFFFF, 32'h0));
        fq[(fidx + 0) % 64] = v3(32'h400, 32'hFFFFFF00, 32'h00010000);
        fq[(fidx + 1) % 64] = v3(32'hFFFFFF00, 32'h100, 32'hFFFFFF00);
`ifdef VELOCITY_SATURATE_EN
        exp2 = v3(32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF);
`else
        exp2 = v3(32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF);
`endif
        force_valid = 1'b1; out_ready = 1'b1;
        h0 = n_hs; b0 = n_bad;
        run_pass(cyc);
        check("basic_done_cycle", cyc, 11);
        check("basic_handshakes", n_hs - h0, 2);
        check("basic_addr1", hs_addr[h0 % 64], 8'd1);
        check("basic_addr2", hs_addr[(h0 + 1) % 64], 8'd2);
        check("basic_data1", hs_data[h0 % 64], v3(32'h9, 32'hF, 32'h200));
        check("ovf_data2", hs_data[(h0 + 1) % 64], exp2);
        check("basic_mem1", mem[1], v3(32'h9, 32'hF, 32'h200));
        check("ovf_mem2", mem[2], exp2);
        check("basic_mem0_kept", mem[0], 96'd2);

        // backpressure and force gaps
        force_valid = 1'b0; out_ready = 1'b0;
        mem_wr(8'd0, 96'd1);
        mem_wr(8'd1, v3(32'd1, 32'd2, 32'd3));
        fq[fidx % 64] = v3(32'h100, 32'h100, 32'h100);
        @(posedge clock); #1; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        wait_fready("bp_reach_fwait");
        stable = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            stable &= force_ready && !out_valid;
        end
        check("bp_force_gap_stall", stable, 1'b1);
        force_valid = 1'b1;
        @(posedge clock); #1;
        force_valid = 1'b0;
        d = out_data;
        w0 = n_wren;
        stable = 1'b1;
        repeat (5) begin
            stable &= out_valid && (out_data == d) && (out_addr == 8'd1) && !ram_wren;
            @(posedge clock); #1;
        end
        check("bp_outputs_stable", stable, 1'b1);
        check("bp_data", d, v3(32'd2, 32'd3, 32'd4));
        out_ready = 1'b1;
        #1;
        check("bp_wren_at_handshake", ram_wren, 1'b1);
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("bp_done", done, 1'b1);
        check("bp_single_write", n_wren - w0, 1);
        check("bp_mem1", mem[1], v3(32'd2, 32'd3, 32'd4));
        @(posedge clock); #1;
        check("bp_idle", busy, 1'b0);

        // reset during F_WAIT of particle 2 of 3
        mem_wr(8'd0, 96'd3);
        for (int i = 1; i <= 3; i++) mem_wr(8'(i), v3(32'd1, 32'd2, 32'd3));
        for (int i = 0; i < 4; i++) fq[(fidx + i) % 64] = v3(32'h100, 32'h100, 32'h100);
        out_ready = 1'b1;
        @(posedge clock); #1; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        wait_fready("rst_p1_fwait");
        force_valid = 1'b1;
        @(posedge clock); #1;
        force_valid = 1'b0;
        wait_fready("rst_p2_fwait");
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ctrl", {busy, force_ready, out_valid, ram_rden, ram_wren, done}, 6'b0);
        @(posedge clock); #1;
        rst_n = 1'b1;
        check("rst_mem1_written", mem[1], v3(32'd2, 32'd3, 32'd4));
        check("rst_mem2_kept", mem[2], v3(32'd1, 32'd2, 32'd3));
        check("rst_mem3_kept", mem[3], v3(32'd1, 32'd2, 32'd3));
        force_valid = 1'b1;
        b0 = n_bad;
        run_pass(cyc);
        check("rerun_done_cycle", cyc, 15);
        @(posedge clock); #1;
        check("rerun_mem1", mem[1], v3(32'd3, 32'd4, 32'd5));
        check("rerun_mem3", mem[3], v3(32'd2, 32'd3, 32'd4));
        check("no_bad_access", n_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
